// File: rtl/dmem_map_pkg.sv
// Address map and RX status layout shared by the dmem responder and its bench.
package dmem_map_pkg;

   localparam logic [15:0] MMIO_HI = 16'hFFFF;

   localparam logic [3:0] OFF_LED    = 4'h0;
   localparam logic [3:0] OFF_TIMER  = 4'h1;
   localparam logic [3:0] OFF_RXSTAT = 4'h2;
   localparam logic [3:0] OFF_RXDATA = 4'h3;

   localparam int RXS_NONEMPTY  = 0;
   localparam int RXS_FULL      = 1;
   localparam int RXS_COUNT_LSB = 4;
   localparam int RXS_OVF       = 8;

   function automatic logic [31:0] rxstat_word(input logic       ovf,
                                               input logic [3:0] cnt,
                                               input logic       full,
                                               input logic       nonempty);
      logic [31:0] w;
      w                        = '0;
      w[RXS_OVF]               = ovf;
      w[RXS_COUNT_LSB +: 4]    = cnt;
      w[RXS_FULL]              = full;
      w[RXS_NONEMPTY]          = nonempty;
      return w;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO for bytes arriving from the board I/O side.
module rx_fifo #(
   parameter int AW = 3,
   parameter int DW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot the push lands in.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: storage arrays carry no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window (LED, timer, RX FIFO), 1-cycle read latency.
module dmem_responder
   import dmem_map_pkg::*;
#(
   parameter int    RAM_AW    = 12,
   parameter int    FIFO_AW   = 3,
   parameter int    TIMER_DIV = 1,
   parameter string INIT_FILE = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   input  logic        advance,
   output logic [31:0] q_dmem,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic [15:0] led
);

   localparam int DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIMER_DIV - 1);

   logic [31:0]       ram [2**RAM_AW];
   logic [RAM_AW-1:0] ram_idx;
   logic [3:0]        offset;
   logic              is_mmio;
   logic              ram_wr;
   logic              led_wr;
   logic              timer_wr;
   logic              rxstat_wr;
   logic              rx_pop;
   logic [31:0]       timer;
   logic [DIV_W-1:0]  div_cnt;
   logic              ovf;
   logic [31:0]       rd_next;

   logic [7:0]        fifo_dout;
   logic [FIFO_AW:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;

   wire unused_addr = ^address_dmem;

   assign is_mmio   = (address_dmem[31:16] == MMIO_HI);
   assign offset    = address_dmem[3:0];
   assign ram_idx   = address_dmem[RAM_AW-1:0];
   assign ram_wr    = !is_mmio && wren;
   assign led_wr    = is_mmio && wren && (offset == OFF_LED);
   assign timer_wr  = is_mmio && wren && (offset == OFF_TIMER);
   assign rxstat_wr = is_mmio && wren && (offset == OFF_RXSTAT);
   // Only a retiring load pops, so a frozen pipeline re-reads the same head.
   assign rx_pop    = is_mmio && !wren && advance && (offset == OFF_RXDATA) && !fifo_empty;

   rx_fifo #(
      .AW (FIFO_AW),
      .DW (8)
   ) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (in_valid),
      .pop   (rx_pop),
      .din   (in_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (ram_wr) ram[ram_idx] <= data;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rd_next = '0;
      if (!is_mmio) begin
         rd_next = wren ? data : ram[ram_idx];
      end else begin
         case (offset)
            OFF_LED:    rd_next = {16'b0, led};
            OFF_TIMER:  rd_next = timer;
            OFF_RXSTAT: rd_next = rxstat_word(ovf, 4'(fifo_count), fifo_full, !fifo_empty);
            OFF_RXDATA: rd_next = fifo_empty ? 32'b0 : {24'b0, fifo_dout};
            default:    rd_next = '0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_dmem <= '0;
         led    <= '0;
      end else begin
         q_dmem <= rd_next;
         if (led_wr) led <= data[15:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer   <= '0;
         div_cnt <= '0;
      end else if (timer_wr) begin
         timer   <= '0;
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         timer   <= timer + 32'd1;
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // A fresh overflow takes priority over a same-edge clear so it is never lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
      end else if (in_valid && fifo_full && !rx_pop) begin
         ovf <= 1'b1;
      end else if (rxstat_wr && data[RXS_OVF]) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, LED, timer, RX FIFO, stalls and async reset.
module tb_dmem_responder;
   import dmem_map_pkg::*;

   localparam logic [31:0] A_LED    = 32'hFFFF_0000;
   localparam logic [31:0] A_TIMER  = 32'hFFFF_0001;
   localparam logic [31:0] A_RXSTAT = 32'hFFFF_0002;
   localparam logic [31:0] A_RXDATA = 32'hFFFF_0003;
   localparam logic [31:0] A_IDLE   = 32'h0000_0100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address_dmem = '0;
   logic [31:0] data = '0;
   logic        wren = 1'b0;
   logic        advance = 1'b1;
   logic [31:0] q_dmem;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic [15:0] led;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   dmem_responder dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .advance      (advance),
      .q_dmem       (q_dmem),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .led          (led)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic adv);
      address_dmem = a;
      data         = d;
      wren         = w;
      advance      = adv;
      @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      cyc(A_IDLE, 32'h0, 1'b0, 1'b1);
      in_valid = 1'b0;
   endtask

   initial begin
      #1;
      check("reset_q", q_dmem, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // RAM store/load, alias and write-first
      cyc(32'h5, 32'hDEAD_BEEF, 1'b1, 1'b1);
      cyc(32'h5, 32'h0, 1'b0, 1'b1);
      check("ram_rd", q_dmem, 32'hDEAD_BEEF);
      cyc(32'h1005, 32'h0, 1'b0, 1'b1);
      check("ram_alias", q_dmem, 32'hDEAD_BEEF);
      cyc(32'h7, 32'h1122_3344, 1'b1, 1'b1);
      check("ram_wr_first", q_dmem, 32'h1122_3344);

      // LED and unmapped MMIO
      cyc(A_LED, 32'h1234_ABCD, 1'b1, 1'b1);
      check("led_wr", {16'h0, led}, 32'h0000_ABCD);
      cyc(A_LED, 32'h0, 1'b0, 1'b1);
      check("led_rd", q_dmem, 32'h0000_ABCD);
      cyc(32'hFFFF_0009, 32'h5555_5555, 1'b1, 1'b1);
      cyc(32'hFFFF_0009, 32'h0, 1'b0, 1'b1);
      check("unmapped_rd", q_dmem, 32'h0);
      check("unmapped_wr_led", {16'h0, led}, 32'h0000_ABCD);

      // Timer: cleared by the write edge, then 10 increments before the read edge
      cyc(A_TIMER, 32'h0, 1'b1, 1'b1);
      repeat (10) cyc(A_IDLE, 32'h0, 1'b0, 1'b1);
      cyc(A_TIMER, 32'h0, 1'b0, 1'b1);
      check("timer_10", q_dmem, 32'd10);
      force dut.timer = 32'hFFFF_FFFF;
      #1 release dut.timer;
      cyc(A_TIMER, 32'h0, 1'b0, 1'b1);
      check("timer_max", q_dmem, 32'hFFFF_FFFF);
      cyc(A_TIMER, 32'h0, 1'b0, 1'b1);
      check("timer_wrap", q_dmem, 32'h0);

      // FIFO fill, overflow, drain, clear
      for (int i = 1; i <= 9; i++) push_byte(8'(i));
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("rxstat_full_ovf", q_dmem, 32'h0000_0183);
      for (int i = 1; i <= 8; i++) begin
         cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
         check($sformatf("pop_%0d", i), q_dmem, 32'(i));
      end
      cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
      check("empty_rd", q_dmem, 32'h0);
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("rxstat_ovf_only", q_dmem, 32'h0000_0100);
      cyc(A_RXSTAT, 32'h100, 1'b1, 1'b1);
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("rxstat_cleared", q_dmem, 32'h0);

      // Empty read with same-edge push
      in_valid = 1'b1;
      in_data  = 8'hAA;
      cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
      in_valid = 1'b0;
      check("empty_push_rd", q_dmem, 32'h0);
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("empty_push_stat", q_dmem, 32'h0000_0011);
      cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
      check("empty_push_pop", q_dmem, 32'h0000_00AA);

      // Stalled reads do not pop
      for (int i = 0; i < 3; i++) push_byte(8'h21 + 8'(i));
      for (int i = 0; i < 3; i++) begin
         cyc(A_RXDATA, 32'h0, 1'b0, 1'b0);
         check($sformatf("stall_rd_%0d", i), q_dmem, 32'h21);
      end
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("stall_count", q_dmem, 32'h0000_0031);
      cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
      check("stall_release_pop", q_dmem, 32'h21);

      // Full with simultaneous push and pop
      for (int i = 0; i < 6; i++) push_byte(8'h24 + 8'(i));
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("full_stat", q_dmem, 32'h0000_0083);
      in_valid = 1'b1;
      in_data  = 8'h2A;
      cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
      in_valid = 1'b0;
      check("full_pushpop_rd", q_dmem, 32'h22);
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("full_pushpop_stat", q_dmem, 32'h0000_0083);
      for (int i = 0; i < 8; i++) begin
         cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
         check($sformatf("drain_%0d", i), q_dmem, 32'h23 + 32'(i));
      end

      // Asynchronous reset mid-run with ovf set and 3 bytes held
      for (int i = 0; i < 9; i++) push_byte(8'h31 + 8'(i));
      for (int i = 0; i < 5; i++) cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
      cyc(A_LED, 32'h0000_00FF, 1'b1, 1'b1);
      cyc(A_LED, 32'h0, 1'b0, 1'b1);
      check("pre_reset_q", q_dmem, 32'h0000_00FF);
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("pre_reset_stat", q_dmem, 32'h0000_0131);
      cyc(A_LED, 32'h0, 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      check("async_q", q_dmem, 32'h0);
      check("async_led", {16'h0, led}, 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      cyc(A_RXSTAT, 32'h0, 1'b0, 1'b1);
      check("post_reset_stat", q_dmem, 32'h0);
      cyc(A_RXDATA, 32'h0, 1'b0, 1'b1);
      check("post_reset_rxdata", q_dmem, 32'h0);
      cyc(32'h5, 32'h0, 1'b0, 1'b1);
      check("ram_retained", q_dmem, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
